// File: rtl/check_pkg.sv
// Shared types for the store self-check monitor: FSM states, fail codes and
// an index-width helper that stays legal for a single-entry table.
// No ports; imported by store_check_table and store_check_monitor.
package check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } chk_state_t;

   typedef enum logic [1:0] {
      FC_NONE     = 2'd0,
      FC_MISMATCH = 2'd1,
      FC_ORDER    = 2'd2,
      FC_TIMEOUT  = 2'd3
   } fail_code_t;

   // $clog2(1) is 0, which would give a zero-width index bus.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/store_check_table.sv
// Expected-store table: entry regs with valid/hit flags, parallel address
// compare against the live store, lowest-index selection, completion status.
// Ports: wr_* load an entry; hit_set_i/hit_idx_i mark an entry hit, hit_clr_i
// clears all hit flags; match_* is the lowest open entry whose addr equals
// addr_i; next_idx_o is the lowest open entry; all_hit_o/one_open_o/
// hit_count_o summarise progress. "Open" means valid and not yet hit.
module store_check_table
   import check_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NUM_CHECKS = 4,
   parameter int IDX_W      = idx_width(NUM_CHECKS),
   parameter int HC_W       = $clog2(NUM_CHECKS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic [XLEN-1:0]   wr_addr_i,
   input  logic [XLEN-1:0]   wr_data_i,
   input  logic              hit_set_i,
   input  logic [IDX_W-1:0]  hit_idx_i,
   input  logic              hit_clr_i,
   input  logic [XLEN-1:0]   addr_i,
   output logic              match_any_o,
   output logic [IDX_W-1:0]  match_idx_o,
   output logic [XLEN-1:0]   match_data_o,
   output logic [IDX_W-1:0]  next_idx_o,
   output logic              all_hit_o,
   output logic              one_open_o,
   output logic [HC_W-1:0]   hit_count_o
);

   logic [XLEN-1:0]       addr_q [NUM_CHECKS];
   logic [XLEN-1:0]       data_q [NUM_CHECKS];
   logic [NUM_CHECKS-1:0] valid_q;
   logic [NUM_CHECKS-1:0] hit_q;
   logic [NUM_CHECKS-1:0] open_vec;
   logic [NUM_CHECKS-1:0] cand_vec;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         hit_q   <= '0;
         for (int i = 0; i < NUM_CHECKS; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHECKS; i++) begin
            // Indices >= NUM_CHECKS never match and are silently dropped.
            if (wr_en_i && (wr_idx_i == IDX_W'(i))) begin
               addr_q[i]  <= wr_addr_i;
               data_q[i]  <= wr_data_i;
               valid_q[i] <= 1'b1;
            end
            if (hit_clr_i) begin
               hit_q[i] <= 1'b0;
            end else if (hit_set_i && (hit_idx_i == IDX_W'(i))) begin
               hit_q[i] <= 1'b1;
            end
         end
      end
   end

   assign open_vec = valid_q & ~hit_q;

   // Descending scan so the last assignment wins: lowest index has priority,
   // which is what makes duplicate addresses consume in index order.
   always_comb begin
      cand_vec     = '0;
      match_any_o  = 1'b0;
      match_idx_o  = '0;
      match_data_o = '0;
      next_idx_o   = '0;
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
         cand_vec[i] = open_vec[i] && (addr_q[i] == addr_i);
         if (cand_vec[i]) begin
            match_any_o  = 1'b1;
            match_idx_o  = IDX_W'(i);
            match_data_o = data_q[i];
         end
         if (open_vec[i]) begin
            next_idx_o = IDX_W'(i);
         end
      end
   end

   assign all_hit_o  = (open_vec == '0);
   // Exactly one bit set: a hit this cycle completes the table.
   assign one_open_o = (open_vec != '0) &&
                       ((open_vec & (open_vec - NUM_CHECKS'(1))) == '0);

   always_comb begin
      hit_count_o = '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
         hit_count_o = hit_count_o + HC_W'(hit_q[i]);
      end
   end

endmodule

// File: rtl/store_check_monitor.sv
// Self-check monitor on the memory-stage store bus: compares stores against a
// loadable expected table (ordered or unordered), reports pass/fail + code,
// captures the offending store, counts RUN cycles and enforces a timeout.
// Ports: clk/reset (async active-low); cfg_* table load (IDLE only); start,
// clear; mem_write_i/addr_i/wdata_i store bus; done_o, pass_o, fail_code_o,
// hit_count_o, cycles_o, bad_addr_o/bad_data_o status. 1-cycle latency.
module store_check_monitor
   import check_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NUM_CHECKS = 4,
   parameter int MAX_CYCLES = 500,
   parameter int ORDERED    = 0,
   parameter int CNT_W      = $clog2(MAX_CYCLES + 1),
   parameter int IDX_W      = idx_width(NUM_CHECKS),
   parameter int HC_W       = $clog2(NUM_CHECKS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_we,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic [XLEN-1:0]   cfg_addr,
   input  logic [XLEN-1:0]   cfg_data,
   input  logic              start,
   input  logic              clear,
   input  logic              mem_write_i,
   input  logic [XLEN-1:0]   addr_i,
   input  logic [XLEN-1:0]   wdata_i,
   output logic              done_o,
   output logic              pass_o,
   output logic [1:0]        fail_code_o,
   output logic [HC_W-1:0]   hit_count_o,
   output logic [CNT_W-1:0]  cycles_o,
   output logic [XLEN-1:0]   bad_addr_o,
   output logic [XLEN-1:0]   bad_data_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

   chk_state_t       state_q, state_d;
   fail_code_t       fc_q, fc_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
   logic [XLEN-1:0]  bad_data_q, bad_data_d;

   logic             tbl_we;
   logic             hit_set;
   logic             hit_clr;
   logic             store_fail;
   logic             match_any;
   logic [IDX_W-1:0] match_idx;
   logic [XLEN-1:0]  match_data;
   logic [IDX_W-1:0] next_idx;
   logic             all_hit;
   logic             one_open;

   store_check_table #(
      .XLEN       (XLEN),
      .NUM_CHECKS (NUM_CHECKS),
      .IDX_W      (IDX_W),
      .HC_W       (HC_W)
   ) u_table (
      .clk          (clk),
      .reset        (reset),
      .wr_en_i      (tbl_we),
      .wr_idx_i     (cfg_idx),
      .wr_addr_i    (cfg_addr),
      .wr_data_i    (cfg_data),
      .hit_set_i    (hit_set),
      .hit_idx_i    (match_idx),
      .hit_clr_i    (hit_clr),
      .addr_i       (addr_i),
      .match_any_o  (match_any),
      .match_idx_o  (match_idx),
      .match_data_o (match_data),
      .next_idx_o   (next_idx),
      .all_hit_o    (all_hit),
      .one_open_o   (one_open),
      .hit_count_o  (hit_count_o)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         fc_q       <= FC_NONE;
         cycles_q   <= '0;
         bad_addr_q <= '0;
         bad_data_q <= '0;
      end else begin
         state_q    <= state_d;
         fc_q       <= fc_d;
         cycles_q   <= cycles_d;
         bad_addr_q <= bad_addr_d;
         bad_data_q <= bad_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fc_d       = fc_q;
      cycles_d   = cycles_q;
      bad_addr_d = bad_addr_q;
      bad_data_d = bad_data_q;
      tbl_we     = 1'b0;
      hit_set    = 1'b0;
      hit_clr    = 1'b0;
      store_fail = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tbl_we = cfg_we;
            if (start) begin
               state_d    = ST_RUN;
               fc_d       = FC_NONE;
               cycles_d   = '0;
               bad_addr_d = '0;
               bad_data_d = '0;
               hit_clr    = 1'b1;
            end
         end

         ST_RUN: begin
            if (cycles_q != MAX_CNT) begin
               cycles_d = cycles_q + CNT_W'(1);
            end
            // In ordered mode the lowest matching open entry is the expected
            // one exactly when it is also the lowest open entry overall.
            if (mem_write_i && match_any) begin
               if ((ORDERED != 0) && (match_idx != next_idx)) begin
                  store_fail = 1'b1;
                  fc_d       = FC_ORDER;
               end else if (wdata_i == match_data) begin
                  hit_set = 1'b1;
               end else begin
                  store_fail = 1'b1;
                  fc_d       = FC_MISMATCH;
               end
            end
            // Store faults and completing hits both outrank the timeout.
            if (store_fail) begin
               state_d    = ST_FAIL;
               bad_addr_d = addr_i;
               bad_data_d = wdata_i;
            end else if (all_hit || (hit_set && one_open)) begin
               state_d = ST_PASS;
            end else if (cycles_q == MAX_CNT) begin
               state_d = ST_FAIL;
               fc_d    = FC_TIMEOUT;
            end
         end

         ST_PASS, ST_FAIL: begin
            if (clear) begin
               state_d = ST_IDLE;
               fc_d    = FC_NONE;
               hit_clr = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign done_o      = (state_q == ST_PASS) || (state_q == ST_FAIL);
   assign pass_o      = (state_q == ST_PASS);
   assign fail_code_o = fc_q;
   assign cycles_o    = cycles_q;
   assign bad_addr_o  = bad_addr_q;
   assign bad_data_o  = bad_data_q;

endmodule

// File: tb/tb_store_check_monitor.sv
module tb_store_check_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [31:0] cfg_addr = '0;
   logic [31:0] cfg_data = '0;
   logic        start = 1'b0;
   logic        clear = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;

   // Unordered instance
   logic        u_done, u_pass;
   logic [1:0]  u_fc;
   logic [2:0]  u_hits;
   logic [8:0]  u_cyc;
   logic [31:0] u_baddr, u_bdata;
   // Ordered instance
   logic        o_done, o_pass;
   logic [1:0]  o_fc;
   logic [2:0]  o_hits;
   logic [8:0]  o_cyc;
   logic [31:0] o_baddr, o_bdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   store_check_monitor #(.XLEN(32), .NUM_CHECKS(4), .MAX_CYCLES(500), .ORDERED(0)) u_dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .clear(clear),
      .mem_write_i(mem_write), .addr_i(st_addr), .wdata_i(st_data),
      .done_o(u_done), .pass_o(u_pass), .fail_code_o(u_fc), .hit_count_o(u_hits),
      .cycles_o(u_cyc), .bad_addr_o(u_baddr), .bad_data_o(u_bdata)
   );

   store_check_monitor #(.XLEN(32), .NUM_CHECKS(4), .MAX_CYCLES(500), .ORDERED(1)) u_ord (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start), .clear(clear),
      .mem_write_i(mem_write), .addr_i(st_addr), .wdata_i(st_data),
      .done_o(o_done), .pass_o(o_pass), .fail_code_o(o_fc), .hit_count_o(o_hits),
      .cycles_o(o_cyc), .bad_addr_o(o_baddr), .bad_data_o(o_bdata)
   );

   typedef struct {
      logic        mw;
      logic [31:0] a;
      logic [31:0] d;
      logic        e_done;
      logic        e_pass;
      logic [1:0]  e_fc;
      logic [2:0]  e_hits;
      logic [8:0]  e_cyc;
      logic [1:0]  e_ofc;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_u(input string nm, input logic e_done, input logic e_pass,
                        input logic [1:0] e_fc, input logic [2:0] e_hits, input logic [8:0] e_cyc);
      chk({nm, ".done"}, 32'(u_done), 32'(e_done));
      chk({nm, ".pass"}, 32'(u_pass), 32'(e_pass));
      chk({nm, ".fc"},   32'(u_fc),   32'(e_fc));
      chk({nm, ".hits"}, 32'(u_hits), 32'(e_hits));
      chk({nm, ".cyc"},  32'(u_cyc),  32'(e_cyc));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      mem_write = 1'b1; st_addr = a; st_data = d;
      tick();
      mem_write = 1'b0;
   endtask

   initial begin
      // Entries 0:(100,1) 1:(104,2) 2:(100,1), one vector per RUN edge.
      vecs[0] = '{1'b0, 32'd100, 32'd1, 1'b0, 1'b0, 2'd0, 3'd0, 9'd1, 2'd0};
      vecs[1] = '{1'b1, 32'd8,   32'd5, 1'b0, 1'b0, 2'd0, 3'd0, 9'd2, 2'd0};
      vecs[2] = '{1'b1, 32'd104, 32'd2, 1'b0, 1'b0, 2'd0, 3'd1, 9'd3, 2'd2};
      vecs[3] = '{1'b1, 32'd100, 32'd1, 1'b0, 1'b0, 2'd0, 3'd2, 9'd4, 2'd2};
      vecs[4] = '{1'b1, 32'd104, 32'd2, 1'b0, 1'b0, 2'd0, 3'd2, 9'd5, 2'd2};
      vecs[5] = '{1'b1, 32'd100, 32'd1, 1'b1, 1'b1, 2'd0, 3'd3, 9'd6, 2'd2};
      vecs[6] = '{1'b1, 32'd100, 32'd9, 1'b1, 1'b1, 2'd0, 3'd3, 9'd6, 2'd2};

      // Reset state
      #1;
      chk_u("reset", 1'b0, 1'b0, 2'd0, 3'd0, 9'd0);
      chk("reset.bad_addr", u_baddr, 32'd0);
      chk("reset.bad_data", u_bdata, 32'd0);
      do_reset();

      // Single entry, matching store on RUN edge 40
      load(2'd0, 32'd212, 32'd511);
      do_start();
      chk_u("run0", 1'b0, 1'b0, 2'd0, 3'd0, 9'd0);
      repeat (39) tick();
      store(32'd212, 32'd511);
      chk_u("pass40", 1'b1, 1'b1, 2'd0, 3'd1, 9'd40);
      chk("pass40.ord", 32'(o_pass), 32'd1);

      // Mismatch, then a correct store must not change status
      do_clear();
      chk("clear.done", 32'(u_done), 32'd0);
      do_start();
      store(32'd212, 32'd510);
      chk_u("mism", 1'b1, 1'b0, 2'd1, 3'd0, 9'd1);
      chk("mism.bad_addr", u_baddr, 32'd212);
      chk("mism.bad_data", u_bdata, 32'd510);
      store(32'd212, 32'd511);
      chk_u("mism_sticky", 1'b1, 1'b0, 2'd1, 3'd0, 9'd1);
      chk("mism_sticky.bad_data", u_bdata, 32'd510);

      // Table-driven run with a duplicate address
      do_reset();
      load(2'd0, 32'd100, 32'd1);
      load(2'd1, 32'd104, 32'd2);
      load(2'd2, 32'd100, 32'd1);
      do_start();
      for (int i = 0; i < 7; i++) begin
         mem_write = vecs[i].mw; st_addr = vecs[i].a; st_data = vecs[i].d;
         tick();
         chk_u($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_pass,
               vecs[i].e_fc, vecs[i].e_hits, vecs[i].e_cyc);
         chk($sformatf("vec%0d.ord_fc", i), 32'(o_fc), 32'(vecs[i].e_ofc));
      end
      mem_write = 1'b0;
      chk("vec.ord_bad_addr", o_baddr, 32'd104);

      // Ordered vs unordered on the same out-of-order sequence
      do_reset();
      load(2'd0, 32'd100, 32'd1);
      load(2'd1, 32'd104, 32'd2);
      do_start();
      store(32'd104, 32'd2);
      chk("order.ord_done", 32'(o_done), 32'd1);
      chk("order.ord_fc", 32'(o_fc), 32'd2);
      chk("order.ord_bad_addr", o_baddr, 32'd104);
      chk("order.ord_bad_data", o_bdata, 32'd2);
      chk_u("order.unord", 1'b0, 1'b0, 2'd0, 3'd1, 9'd1);
      store(32'd100, 32'd1);
      chk_u("order.unord_pass", 1'b1, 1'b1, 2'd0, 3'd2, 9'd2);

      // Timeout
      do_clear();
      chk("clear.hits", 32'(u_hits), 32'd0);
      do_start();
      repeat (500) tick();
      chk_u("to.edge500", 1'b0, 1'b0, 2'd0, 3'd0, 9'd500);
      tick();
      chk_u("to.fail", 1'b1, 1'b0, 2'd3, 3'd0, 9'd500);
      chk("to.ord_fc", 32'(o_fc), 32'd3);

      // Completing hit on the timeout cycle wins
      do_clear();
      do_start();
      store(32'd100, 32'd1);
      repeat (499) tick();
      chk_u("to2.edge500", 1'b0, 1'b0, 2'd0, 3'd1, 9'd500);
      store(32'd104, 32'd2);
      chk_u("to2.pass", 1'b1, 1'b1, 2'd0, 3'd2, 9'd500);
      chk("to2.ord_pass", 32'(o_pass), 32'd1);

      // Asynchronous reset mid-RUN with one of two entries hit
      do_clear();
      do_start();
      store(32'd100, 32'd1);
      chk("rst.hits_before", 32'(u_hits), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk_u("rst.async", 1'b0, 1'b0, 2'd0, 3'd0, 9'd0);
      chk("rst.ord_hits", 32'(o_hits), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      do_start();
      tick();
      chk_u("rst.empty_pass", 1'b1, 1'b1, 2'd0, 3'd0, 9'd1);

      // Unwatched stores and cfg_we during RUN
      do_reset();
      load(2'd0, 32'd212, 32'd511);
      do_start();
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_addr = 32'd300; cfg_data = 32'd7;
      mem_write = 1'b1; st_addr = 32'd300; st_data = 32'd7;
      tick();
      cfg_we = 1'b0; mem_write = 1'b0;
      chk_u("cfgrun", 1'b0, 1'b0, 2'd0, 3'd0, 9'd1);
      st_addr = 32'd212; st_data = 32'd511;
      tick();
      chk_u("mw_low", 1'b0, 1'b0, 2'd0, 3'd0, 9'd2);
      store(32'd0, 32'd0);
      store(32'd8, 32'd8);
      chk_u("unwatched", 1'b0, 1'b0, 2'd0, 3'd0, 9'd4);
      store(32'd212, 32'd511);
      chk_u("table_kept", 1'b1, 1'b1, 2'd0, 3'd1, 9'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
